// File: rtl/sha256_block_packer_if.sv
// Stream-in / block-out bus of the SHA-256 block packer.
// "master" is the host-side view; "slave" is the packer's view.
interface sha256_block_packer_if #(
    parameter int unsigned IN_BYTES = 4
);
    localparam int unsigned DW  = 8 * IN_BYTES;
    localparam int unsigned NBW = $clog2(IN_BYTES + 1);

    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic           s_last;
    logic [NBW-1:0] s_nbytes;
    logic           m_valid;
    logic           m_ready;
    logic [511:0]   m_block;
    logic           m_first;
    logic           m_last;
    logic           err_len;

    modport master (
        output s_valid, s_data, s_last, s_nbytes, m_ready,
        input  s_ready, m_valid, m_block, m_first, m_last, err_len
    );

    modport slave (
        input  s_valid, s_data, s_last, s_nbytes, m_ready,
        output s_ready, m_valid, m_block, m_first, m_last, err_len
    );
endinterface

// File: rtl/sha256_block_packer.sv
// Packs a byte stream into padded 512-bit SHA-256 blocks with the 64-bit
// length field, flagging the first and last block of each message.
module sha256_block_packer #(
    parameter int unsigned IN_BYTES = 4,
    parameter int unsigned LEN_W    = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_block_packer_if.slave bus
);
    localparam int unsigned DW     = 8 * IN_BYTES;
    localparam int unsigned NBW    = $clog2(IN_BYTES + 1);
    localparam int unsigned NBW1   = NBW + 1;
    localparam int unsigned BLK_W  = 512;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned LAST_P = 55;
    localparam int unsigned FULL_P = 64;

    typedef enum logic [1:0] {ACCEPT, PAD, EMIT, EMIT_LEN} state_e;

    state_e           state_q, state_d;
    logic [BLK_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0] p_q, p_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             first_pend_q, first_pend_d;
    logic             len_pend_q, len_pend_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [BLK_W-1:0] m_block_q, m_block_d;
    logic             m_first_q, m_first_d;
    logic             m_last_q, m_last_d;
    logic             err_len_q, err_len_d;

    logic [NBW-1:0]   nb_c;
    logic [8:0]       shamt_c;
    logic [BLK_W-1:0] wr_mask_c, wr_data_c, buf_wr_c, pad_c;
    logic [LEN_W-1:0] add_c;
    logic [LEN_W:0]   sum_c;
    logic [63:0]      len_c;
    logic [IDX_W-1:0] idx_next_c;
    logic             hs_c;

    // Beat write, length accumulation and the padded-block datapath
    always_comb begin
        nb_c       = ({1'b0, bus.s_nbytes} > NBW1'(IN_BYTES)) ? NBW'(IN_BYTES) : bus.s_nbytes;
        shamt_c    = {byte_idx_q[5:0], 3'b000};
        wr_mask_c  = {{DW{1'b1}}, {(BLK_W-DW){1'b0}}} >> shamt_c;
        wr_data_c  = {bus.s_data, {(BLK_W-DW){1'b0}}} >> shamt_c;
        buf_wr_c   = (buf_q & ~wr_mask_c) | wr_data_c;
        add_c      = bus.s_last ? LEN_W'({nb_c, 3'b000}) : LEN_W'(DW);
        sum_c      = {1'b0, bit_cnt_q} + {1'b0, add_c};
        len_c      = 64'(bit_cnt_q);
        idx_next_c = byte_idx_q + IDX_W'(IN_BYTES);
        hs_c       = m_valid_q && bus.m_ready;

        // Bytes past p are stale buffer contents and must be forced to zero
        pad_c = '0;
        for (int i = 0; i < 64; i++) begin
            if (IDX_W'(i) < p_q) begin
                pad_c[BLK_W-1-8*i -: 8] = buf_q[BLK_W-1-8*i -: 8];
            end else if (IDX_W'(i) == p_q) begin
                pad_c[BLK_W-1-8*i -: 8] = 8'h80;
            end
        end
        if (p_q <= IDX_W'(LAST_P)) begin
            pad_c[63:0] = len_c;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        byte_idx_d   = byte_idx_q;
        p_d          = p_q;
        bit_cnt_d    = bit_cnt_q;
        first_pend_d = first_pend_q;
        len_pend_d   = len_pend_q;
        s_ready_d    = s_ready_q;
        m_valid_d    = m_valid_q;
        m_block_d    = m_block_q;
        m_first_d    = m_first_q;
        m_last_d     = m_last_q;
        err_len_d    = err_len_q;

        case (state_q)
            ACCEPT: begin
                s_ready_d = 1'b1;
                if (bus.s_valid && s_ready_q) begin
                    buf_d     = buf_wr_c;
                    bit_cnt_d = sum_c[LEN_W-1:0];
                    if (sum_c[LEN_W]) begin
                        err_len_d = 1'b1;
                    end
                    if (bus.s_last) begin
                        p_d       = byte_idx_q + IDX_W'(nb_c);
                        s_ready_d = 1'b0;
                        state_d   = PAD;
                    end else if (idx_next_c == IDX_W'(FULL_P)) begin
                        byte_idx_d = '0;
                        m_block_d  = buf_wr_c;
                        m_valid_d  = 1'b1;
                        m_first_d  = first_pend_q;
                        m_last_d   = 1'b0;
                        len_pend_d = 1'b0;
                        s_ready_d  = 1'b0;
                        state_d    = EMIT;
                    end else begin
                        byte_idx_d = idx_next_c;
                    end
                end
            end
            PAD: begin
                byte_idx_d = '0;
                m_block_d  = pad_c;
                m_valid_d  = 1'b1;
                m_first_d  = first_pend_q;
                m_last_d   = (p_q <= IDX_W'(LAST_P));
                len_pend_d = (p_q > IDX_W'(LAST_P));
                state_d    = EMIT;
            end
            EMIT, EMIT_LEN: begin
                if (hs_c) begin
                    first_pend_d = 1'b0;
                    if (len_pend_q) begin
                        // The 0x80 marker only lands here when the data filled the block
                        m_block_d  = {(p_q == IDX_W'(FULL_P)) ? 8'h80 : 8'h00, 440'd0, len_c};
                        m_first_d  = 1'b0;
                        m_last_d   = 1'b1;
                        len_pend_d = 1'b0;
                        state_d    = EMIT_LEN;
                    end else begin
                        m_valid_d = 1'b0;
                        s_ready_d = 1'b1;
                        state_d   = ACCEPT;
                        if (m_last_q) begin
                            byte_idx_d   = '0;
                            bit_cnt_d    = '0;
                            err_len_d    = 1'b0;
                            first_pend_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCEPT;
            buf_q        <= '0;
            byte_idx_q   <= '0;
            p_q          <= '0;
            bit_cnt_q    <= '0;
            first_pend_q <= 1'b1;
            len_pend_q   <= 1'b0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_block_q    <= '0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            byte_idx_q   <= byte_idx_d;
            p_q          <= p_d;
            bit_cnt_q    <= bit_cnt_d;
            first_pend_q <= first_pend_d;
            len_pend_q   <= len_pend_d;
            s_ready_q    <= s_ready_d;
            m_valid_q    <= m_valid_d;
            m_block_q    <= m_block_d;
            m_first_q    <= m_first_d;
            m_last_q     <= m_last_d;
            err_len_q    <= err_len_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_block = m_block_q;
    assign bus.m_first = m_first_q;
    assign bus.m_last  = m_last_q;
    assign bus.err_len = err_len_q;
endmodule

// File: doc/sha256_block_packer.md
Name: sha256_block_packer

Overview:
- Parametrised successor to the byte-serial SHA-256 front end.
- Accepts a message stream IN_BYTES bytes per beat with valid/ready backpressure and a byte count on the final beat.
- Applies FIPS 180-4 padding and the 64-bit length field, then emits complete 512-bit blocks with first/last flags over a valid/ready interface.
- Sits between the host byte stream and the SHA-256 compression core. Back-to-back messages are supported without a start pulse.

Parameters:
IN_BYTES, 4, bytes per input beat; legal values 1, 2, 4, 8 (64 % IN_BYTES == 0, so a beat never straddles a block)
LEN_W, 64, width of the internal bit-length counter; zero-extended into the 64-bit length field; legal range 16..64

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input beat valid
s_ready  output  1  packer can accept a beat
s_data  input  8*IN_BYTES  message bytes; first byte in bits [8*IN_BYTES-1 -: 8]
s_last  input  1  beat is the final beat of the message
s_nbytes  input  $clog2(IN_BYTES+1)  valid bytes on the last beat, 0..IN_BYTES; ignored when s_last=0
m_valid  output  1  block valid
m_ready  input  1  downstream accepts block
m_block  output  512  block, byte 0 in [511:504]
m_first  output  1  block is the first block of a message (core loads IV)
m_last  output  1  block is the final block of a message
err_len  output  1  sticky: bit counter wrapped during the current message

Behaviour:
- Reset (rst_n low, async): state ACCEPT, byte_idx=0, bit_cnt=0, first_pend=1. Outputs: s_ready=0, m_valid=0, m_block=0, m_first=0, m_last=0, err_len=0. After release, s_ready=1 from the first clock edge.
- Reset mid-message discards all buffered data. No partial block is emitted.
- States: ACCEPT, PAD, EMIT, EMIT_LEN.
- ACCEPT: s_ready=1. The beat transfers when s_valid && s_ready.
  - Non-last beat: writes IN_BYTES bytes at byte_idx; byte_idx += IN_BYTES; bit_cnt += 8*IN_BYTES.
  - If byte_idx reaches 64 → EMIT with m_last=0, m_valid rising on the next cycle (latency 1).
  - Last beat: writes s_nbytes bytes; p = byte_idx + s_nbytes; bit_cnt += 8*s_nbytes → PAD.
- PAD (1 cycle, s_ready=0): computes the padded block from p.
  - p<=55: 0x80 at byte p, zeros to byte 55, bit_cnt in bytes 56..63; m_last=1 → EMIT. Last beat to m_valid latency is 2 cycles.
  - 56<=p<=63: 0x80 at byte p, zeros after; m_last=0 → EMIT, then EMIT_LEN with block {448'd0, len}.
  - p==64: block unchanged, m_last=0 → EMIT, then EMIT_LEN with block {8'h80, 440'd0, len}.
- EMIT / EMIT_LEN: m_valid=1. m_block, m_first and m_last are held stable until m_ready. s_ready=0.
  - On handshake, go to EMIT_LEN if a length block is pending.
  - Otherwise: if the block was last, clear byte_idx, bit_cnt and err_len, set first_pend=1, and go to ACCEPT; else go to ACCEPT to refill.
  - m_first = first_pend when the block is presented. first_pend clears on that block's handshake.
  - An EMIT_LEN block never has m_first=1 and always has m_last=1.
- Buffer bytes beyond the written ones are don't-care until PAD; PAD must explicitly zero them.
- Empty message: a last beat with s_nbytes=0 at byte_idx=0 gives a single block 0x80, zeros, length 0.
- len = {(64-LEN_W)'b0, bit_cnt}.
  - If bit_cnt overflows, err_len sets and stays set until the message completes.
  - The counter wraps modulo 2^LEN_W.
- Beats are never accepted while any block is pending. There is no simultaneous accept and emit.
- s_nbytes > IN_BYTES is illegal. The design clamps it to IN_BYTES.

Test Plan:
- IN_BYTES=1, "abc" (3 beats, s_last/s_nbytes=1 on 'c') → one block 0x61626380, 0…0, low 64 bits 0x18; m_first=m_last=1. Through the core the digest is ba7816bf…f20015ad.
- IN_BYTES=4, empty message (first beat s_last=1, s_nbytes=0) → one block 0x80, 0…0, len 0; m_first=m_last=1.
- IN_BYTES=8, 55-byte vs 56-byte messages:
  - 55 bytes → 1 block, length 0x1B8.
  - 56 bytes → 2 blocks; the first has 0x80 at byte 56 and m_last=0; the second is zeros with length 0x1C0 and m_last=1.
- IN_BYTES=4, 64-byte message (16th beat last, s_nbytes=4) → data block (m_first=1, m_last=0), then {0x80, 0…, 0x200} with m_last=1.
- Backpressure: hold m_ready=0 for 10 cycles with the 2-block message → m_block/m_first/m_last stable, s_ready=0 throughout. A second message sent immediately after produces m_first=1 on its first block.
- Async reset: assert rst_n low mid-block (byte_idx=20), no clock edge → m_valid=0, s_ready=0 immediately. After release, a fresh "abc" gives the same result as the first scenario. With LEN_W=16, a message longer than 8191 bytes → err_len=1 until its last block's handshake.
